// File: rtl/reg_pipe_chain_pkg.sv
// Shared helpers for the reg_pipe_chain register pipeline.
package reg_pipe_chain_pkg;

    // Bits needed to count 0..depth valid stages.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One pipeline stage: a valid bit and a WIDTH-bit data register with load/clear.
module reg_pipe_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             flush,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d_in,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    // Data only moves on a transfer; a clear drops the valid bit but keeps d.
    always_ff @(posedge CLK) begin
        if (reset || flush) begin
            v <= 1'b0;
            d <= RESET_VAL;
        end else if (load) begin
            v <= 1'b1;
            d <= d_in;
        end else if (clear) begin
            v <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_pipe_chain.sv
// Flow-controlled register pipeline with bubble collapsing, flush and occupancy count.
module reg_pipe_chain
    import reg_pipe_chain_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [occ_w(DEPTH)-1:0]   occupancy
);

    localparam int OCC_W = occ_w(DEPTH);

    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] src_v;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] clear;
    logic [WIDTH-1:0] d     [DEPTH];
    logic [WIDTH-1:0] src_d [DEPTH];

    // Ready ripples back from the output: an empty stage, or one that is
    // draining forward, can take a new word this cycle.
    always_comb begin
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = !v[i] || rdy[i+1];
        end
    end

    always_comb begin
        src_v[0] = in_valid;
        src_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            src_v[i] = v[i-1];
            src_d[i] = d[i-1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            load[i]  = rdy[i] && src_v[i];
            clear[i] = rdy[i] && !src_v[i];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        reg_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .CLK   (CLK),
            .reset (reset),
            .flush (flush),
            .load  (load[i]),
            .clear (clear[i]),
            .d_in  (src_d[i]),
            .v     (v[i]),
            .d     (d[i])
        );
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(v[i]);
        end
    end

    assign in_ready  = rdy[0] && !flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

endmodule
